// File: rtl/serialtopara_rx_if.sv
// Bundle of the serial lane inputs, FIFO status and recovered-symbol outputs of serialtopara_rx.
// Latency: none (wires only).
// Backpressure: fifo0_full/fifo1_full travel from FIFO side to receiver; no other flow control.
interface serialtopara_rx_if #(
  parameter int DATA_SIZE = 8
);
  logic                 in0;
  logic                 in1;
  logic                 fifo0_full;
  logic                 fifo1_full;
  logic [DATA_SIZE-1:0] out0;
  logic [DATA_SIZE-1:0] out1;
  logic                 push_0;
  logic                 push_1;
  logic                 active0;
  logic                 active1;
  logic                 overflow0;
  logic                 overflow1;

  // Serial source / FIFO side: drives bit streams and full flags, observes recovered symbols.
  modport master (
    output in0, in1, fifo0_full, fifo1_full,
    input  out0, out1, push_0, push_1, active0, active1, overflow0, overflow1
  );

  // Receiver side.
  modport slave (
    input  in0, in1, fifo0_full, fifo1_full,
    output out0, out1, push_0, push_1, active0, active1, overflow0, overflow1
  );
endinterface

// File: rtl/serialtopara_rx.sv
// Two-lane serial-to-parallel receiver: comma search, byte alignment, IDLE stripping, FIFO push.
// Latency: push/out register on the edge sampling a symbol's LSB, valid the following cycle.
// Backpressure: a data symbol arriving while fifoN_full=1 is dropped and sets sticky overflowN.
// Optional feature: define SP_LOSS_DETECT_EN to drop back to SEARCH after 8 consecutive
// boundary COMMA symbols while ACTIVE (link-loss detection). Default build leaves it out.
module serialtopara_rx #(
  parameter int                   DATA_SIZE  = 8,      // only 8 is supported
  parameter logic [DATA_SIZE-1:0] COMMA      = 8'hBC,
  parameter logic [DATA_SIZE-1:0] IDLE       = 8'h7C,
  parameter int                   SYNC_COUNT = 4       // 2..4 with the 2-bit comma counter
) (
  input logic              clk,
  input logic              reset,
  serialtopara_rx_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Comma count value that, when one more aligned COMMA arrives, completes synchronisation.
  localparam logic [1:0] SYNC_LAST = 2'(SYNC_COUNT - 1);

  // Both lanes are identical and fully independent; only the port mapping differs.
  for (genvar g = 0; g < 2; g++) begin : g_lane

    logic                 din;
    logic                 full;

    state_t               state_q;
    state_t               state_d;
    logic [DATA_SIZE-2:0] sr_q;
    logic [2:0]           bit_q;
    logic [2:0]           bit_d;
    logic [1:0]           comma_q;
    logic [1:0]           comma_d;

    logic [DATA_SIZE-1:0] out_q;
    logic [DATA_SIZE-1:0] out_d;
    logic                 push_q;
    logic                 push_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic [DATA_SIZE-1:0] window;
    logic                 boundary;
    logic                 is_comma;
    logic                 is_idle;

`ifdef SP_LOSS_DETECT_EN
    // Counts consecutive boundary COMMAs seen while ACTIVE; the 8th one means the link is gone.
    logic [2:0]           loss_q;
    logic [2:0]           loss_d;
`endif

    if (g == 0) begin : g_map0
      assign din           = bus.in0;
      assign full          = bus.fifo0_full;
      assign bus.out0      = out_q;
      assign bus.push_0    = push_q;
      assign bus.active0   = (state_q == ACTIVE);
      assign bus.overflow0 = ovf_q;
    end else begin : g_map1
      assign din           = bus.in1;
      assign full          = bus.fifo1_full;
      assign bus.out1      = out_q;
      assign bus.push_1    = push_q;
      assign bus.active1   = (state_q == ACTIVE);
      assign bus.overflow1 = ovf_q;
    end

    // The window includes the bit being sampled this edge, so a match is seen on the LSB edge.
    assign window   = {sr_q, din};
    assign is_comma = (window == COMMA);
    assign is_idle  = (window == IDLE);
    // bit_q reaches 7 on the 8th edge after the last boundary; SEARCH has no boundaries.
    assign boundary = (state_q != SEARCH) && (bit_q == 3'd7);

    // State register: lane FSM, shift history, bit and comma counters.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= SEARCH;
        sr_q    <= '0;
        bit_q   <= '0;
        comma_q <= '0;
`ifdef SP_LOSS_DETECT_EN
        loss_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        sr_q    <= window[DATA_SIZE-2:0];
        bit_q   <= bit_d;
        comma_q <= comma_d;
`ifdef SP_LOSS_DETECT_EN
        loss_q  <= loss_d;
`endif
      end
    end

    // Next-state logic: bit-level comma hunt in SEARCH, symbol-level checks at boundaries after.
    always_comb begin
      state_d = state_q;
      bit_d   = bit_q + 3'd1;
      comma_d = comma_q;
`ifdef SP_LOSS_DETECT_EN
      loss_d  = loss_q;
`endif
      case (state_q)
        SEARCH: begin
          // Hold the bit counter at 0 so the first boundary lands 8 edges after the match.
          bit_d   = 3'd0;
          comma_d = 2'd0;
          if (is_comma) begin
            state_d = ALIGN;
            comma_d = 2'd1;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              if (comma_q == SYNC_LAST) begin
                state_d = ACTIVE;
                comma_d = SYNC_LAST;
`ifdef SP_LOSS_DETECT_EN
                loss_d  = 3'd0;
`endif
              end else begin
                comma_d = comma_q + 2'd1;
              end
            end else begin
              // A non-comma interrupts the run: throw the alignment away and hunt again.
              state_d = SEARCH;
              comma_d = 2'd0;
            end
          end
        end
        ACTIVE: begin
          // Without loss detection only reset leaves ACTIVE; misplaced commas are ignored.
`ifdef SP_LOSS_DETECT_EN
          if (boundary) begin
            if (is_comma) begin
              if (loss_q == 3'd7) begin
                state_d = SEARCH;
                comma_d = 2'd0;
                loss_d  = 3'd0;
              end else begin
                loss_d = loss_q + 3'd1;
              end
            end else begin
              loss_d = 3'd0;
            end
          end
`endif
        end
        default: begin
          state_d = SEARCH;
          comma_d = 2'd0;
        end
      endcase
    end

    // Output logic: push data symbols at ACTIVE boundaries, or record the drop when full.
    always_comb begin
      out_d  = out_q;
      push_d = 1'b0;
      ovf_d  = ovf_q;
      if ((state_q == ACTIVE) && boundary && !is_comma && !is_idle) begin
        if (!full) begin
          out_d  = window;
          push_d = 1'b1;
        end else begin
          ovf_d  = 1'b1;
        end
      end
    end

    // Output registers: out holds between pushes, push is a single-cycle strobe, overflow sticks.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q  <= '0;
        push_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        out_q  <= out_d;
        push_q <= push_d;
        ovf_q  <= ovf_d;
      end
    end

  end : g_lane

endmodule

// File: tb/tb_serialtopara_rx.sv
// Testbench for serialtopara_rx: table-driven lane-0 flow plus hand-written corner sequences,
// with a per-lane scoreboard of expected pushed symbols.
module tb_serialtopara_rx;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] IC = 8'h7C;
`ifdef SP_LOSS_DETECT_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serialtopara_rx_if #(.DATA_SIZE(8)) bus ();

  serialtopara_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  typedef struct {
    logic [7:0] sym;
    bit         full;
    bit         exp_push;
    bit         exp_act;
    bit         exp_ovf;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every push strobe must match the oldest expected symbol of its lane.
  always @(posedge clk) begin
    #1;
    if (bus.push_0 === 1'b1) begin
      if (exp0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected push_0: out0=%0h, none expected", bus.out0);
      end else begin
        check("sb.out0", 32'(bus.out0), 32'(exp0.pop_front()));
      end
    end
    if (bus.push_1 === 1'b1) begin
      if (exp1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected push_1: out1=%0h, none expected", bus.out1);
      end else begin
        check("sb.out1", 32'(bus.out1), 32'(exp1.pop_front()));
      end
    end
  end

  task automatic step(input logic b0, input logic b1, input logic f0, input logic f1);
    @(negedge clk);
    bus.in0        = b0;
    bus.in1        = b1;
    bus.fifo0_full = f0;
    bus.fifo1_full = f1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [7:0] s0, input logic [7:0] s1,
                          input logic f0, input logic f1);
    for (int i = 7; i >= 0; i--) step(s0[i], s1[i], f0, f1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, {16'h0, bus.out0, bus.out1}, 32'h0);
    check({tag, ".flags"}, {26'h0, bus.push_0, bus.push_1, bus.active0, bus.active1,
                            bus.overflow0, bus.overflow1}, 32'h0);
  endtask

  task automatic check_sb_empty(input string tag);
    check({tag, ".sb0_left"}, 32'(exp0.size()), 32'h0);
    check({tag, ".sb1_left"}, 32'(exp1.size()), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset          = 1'b1;
    bus.in0        = 1'b0;
    bus.in1        = 1'b0;
    bus.fifo0_full = 1'b0;
    bus.fifo1_full = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s39[7];
    bit         a39[7];

    reset          = 1'b1;
    bus.in0        = 1'b0;
    bus.in1        = 1'b0;
    bus.fifo0_full = 1'b0;
    bus.fifo1_full = 1'b0;

    // Lane-0 flow: sync, data, IDLE, full/drop, straddling comma, loss run.
    vt.push_back('{BC,    1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{BC,    1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{BC,    1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{BC,    1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{8'h55, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back('{IC,    1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1});
    vt.push_back('{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1});
    vt.push_back('{8'h0B, 1'b0, 1'b1, 1'b1, 1'b1});  // 0B,C0 hides a BC at bit offset 4
    vt.push_back('{8'hC0, 1'b0, 1'b1, 1'b1, 1'b1});
    vt.push_back('{BC,    1'b0, 1'b0, 1'b1, 1'b1});
    vt.push_back('{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1});  // breaks the comma run
    for (int k = 0; k < 7; k++) vt.push_back('{BC, 1'b0, 1'b0, 1'b1, 1'b1});
    vt.push_back('{BC,    1'b0, 1'b0, !LOSS, 1'b1});

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].exp_push) exp0.push_back(vt[i].sym);
      send_sym(vt[i].sym, 8'h00, vt[i].full, 1'b0);
      check($sformatf("vec%0d.push_0", i), 32'(bus.push_0), 32'(vt[i].exp_push));
      check($sformatf("vec%0d.active0", i), 32'(bus.active0), 32'(vt[i].exp_act));
      check($sformatf("vec%0d.overflow0", i), 32'(bus.overflow0), 32'(vt[i].exp_ovf));
      check($sformatf("vec%0d.active1", i), 32'(bus.active1), 32'h0);
    end
    check("vec.out0_hold", 32'(bus.out0), 32'hA5);
    check_sb_empty("vec");

    // Lane 1 with a 3-bit offset before the comma run; IDLE is stripped, A3 pushed once.
    do_reset("rst38");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_sym(8'h00, BC, 1'b0, 1'b0);
      check($sformatf("off.bc%0d.active1", i), 32'(bus.active1), (i == 3) ? 32'h1 : 32'h0);
    end
    send_sym(8'h00, IC, 1'b0, 1'b0);
    check("off.idle.push_1", 32'(bus.push_1), 32'h0);
    exp1.push_back(8'hA3);
    send_sym(8'h00, 8'hA3, 1'b0, 1'b0);
    check("off.a3.push_1", 32'(bus.push_1), 32'h1);
    send_sym(8'h00, IC, 1'b0, 1'b0);
    check("off.out1_hold", 32'(bus.out1), 32'hA3);
    check("off.active0", 32'(bus.active0), 32'h0);
    check_sb_empty("off");

    // ALIGN aborted by a data symbol, then a full comma run reacquires.
    do_reset("rst39");
    s39 = '{BC, BC, 8'h12, BC, BC, BC, BC};
    a39 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      send_sym(s39[i], 8'h00, 1'b0, 1'b0);
      check($sformatf("abort.s%0d.active0", i), 32'(bus.active0), 32'(a39[i]));
      check($sformatf("abort.s%0d.push_0", i), 32'(bus.push_0), 32'h0);
    end
    check_sb_empty("abort");

    // Both lanes active, reset mid-symbol, then reacquire.
    do_reset("rst41");
    for (int i = 0; i < 4; i++) send_sym(BC, BC, 1'b0, 1'b0);
    check("mid.active_both", {30'h0, bus.active0, bus.active1}, 32'h3);
    exp0.push_back(8'h11);
    exp1.push_back(8'h22);
    send_sym(8'h11, 8'h22, 1'b0, 1'b0);
    check("mid.out_before", {16'h0, bus.out0, bus.out1}, 32'h1122);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_all_zero("mid.async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_sym(BC, BC, 1'b0, 1'b0);
      check($sformatf("mid.re%0d.active", i), {30'h0, bus.active0, bus.active1},
            (i == 3) ? 32'h3 : 32'h0);
    end
    exp0.push_back(8'h66);
    exp1.push_back(8'h99);
    send_sym(8'h66, 8'h99, 1'b0, 1'b0);
    check("mid.push_both", {30'h0, bus.push_0, bus.push_1}, 32'h3);
    send_sym(IC, IC, 1'b0, 1'b0);
    check("mid.ovf_clear", {30'h0, bus.overflow0, bus.overflow1}, 32'h0);
    check_sb_empty("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
